// File: rtl/button_conditioner.sv
// Conditions one raw active-low pushbutton: 2-flop synchroniser, counter debounce,
// single-cycle press/release strobes and hold-to-auto-repeat.
module button_conditioner #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held_long
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_HOLD
  } state_t;

  logic          sync1_reg, sync2_reg;
  logic          pressed_reg, pressed_next;
  logic [CW-1:0] dcnt_reg, dcnt_next;
  logic          accept_press, accept_release;

  state_t        state_reg, state_next;
  logic [CW-1:0] rcnt_reg, rcnt_next;
  logic          repeat_next, held_next;

  logic          press_pulse_reg, release_pulse_reg;
  logic          repeat_pulse_reg, held_long_reg;

  // Debounce: sync2 is active-low, so it agrees with the accepted level when the two differ.
  always_comb begin
    pressed_next   = pressed_reg;
    dcnt_next      = dcnt_reg;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    if (sync2_reg != pressed_reg) begin
      dcnt_next = '0;
    end else if (dcnt_reg == DEB_LAST) begin
      pressed_next   = ~pressed_reg;
      dcnt_next      = '0;
      accept_press   = ~pressed_reg;
      accept_release = pressed_reg;
    end else begin
      dcnt_next = dcnt_reg + 1'b1;
    end
  end

  // Repeat FSM; an accepted release overrides whatever the current state wants.
  always_comb begin
    state_next  = state_reg;
    rcnt_next   = rcnt_reg;
    repeat_next = 1'b0;
    if (accept_release) begin
      state_next = ST_IDLE;
      rcnt_next  = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept_press) begin
            repeat_next = 1'b1;
            rcnt_next   = '0;
            state_next  = REPEAT_EN ? ST_DELAY : ST_HOLD;
          end
        end
        ST_DELAY: begin
          if (rcnt_reg == HOLD_LAST) begin
            repeat_next = 1'b1;
            rcnt_next   = '0;
            state_next  = ST_REPEAT;
          end else begin
            rcnt_next = rcnt_reg + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (rcnt_reg == REP_LAST) begin
            repeat_next = 1'b1;
            rcnt_next   = '0;
          end else begin
            rcnt_next = rcnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          rcnt_next = rcnt_reg;
        end
        default: begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
    held_next = (state_next == ST_REPEAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg         <= 1'b1;
      sync2_reg         <= 1'b1;
      pressed_reg       <= 1'b0;
      dcnt_reg          <= '0;
      state_reg         <= ST_IDLE;
      rcnt_reg          <= '0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      repeat_pulse_reg  <= 1'b0;
      held_long_reg     <= 1'b0;
    end else begin
      sync1_reg         <= button_n;
      sync2_reg         <= sync1_reg;
      pressed_reg       <= pressed_next;
      dcnt_reg          <= dcnt_next;
      state_reg         <= state_next;
      rcnt_reg          <= rcnt_next;
      press_pulse_reg   <= accept_press;
      release_pulse_reg <= accept_release;
      repeat_pulse_reg  <= repeat_next;
      held_long_reg     <= held_next;
    end
  end

  assign pressed       = pressed_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign repeat_pulse  = repeat_pulse_reg;
  assign held_long     = held_long_reg;

endmodule
